// File: rtl/mem_stage_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Definitions shared by the MEM-stage load/store unit and its data RAM:
//   size_e  - access size encodings (byte/half/word/doubleword)
//   state_e - LSU control states (IDLE, WAIT for read data)
//   lane_be - byte-lane enable mask for an access size and byte offset
// ---------------------------------------------------------------------------
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Lane mask for up to 8 byte lanes. The caller keeps only the low
    // DATA_W/8 bits. Offsets are assumed aligned for the access size; the
    // low offset bits are masked so the mask is always contiguous.
    function automatic logic [7:0] lane_be(input size_e size, input logic [2:0] off);
        case (size)
            SZ_BYTE: return 8'b0000_0001 << off;
            SZ_HALF: return 8'b0000_0011 << {off[2:1], 1'b0};
            SZ_WORD: return 8'b0000_1111 << {off[2], 2'b00};
            default: return 8'b1111_1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_ram.sv
// ---------------------------------------------------------------------------
// lsu_ram
// Single-port data RAM with byte-enable synchronous write and a RD_LAT-deep
// registered read pipeline: the word at addr on edge N appears on rdata
// after RD_LAT edges.
//   clk     in  clock, rising edge
//   addr    in  word address
//   wdata   in  write data (already lane-replicated)
//   byte_en in  per-byte write enables
//   we      in  write strobe
//   rdata   out read data, RD_LAT cycles after addr was presented
// ---------------------------------------------------------------------------
module lsu_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic                  we,
    output logic [DATA_W-1:0]     rdata
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [RD_LAT];

    // NOTE: the array has no reset branch; a RAM cannot be cleared in one
    // cycle, and leaving reset out lets synthesis map it onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < LANES; b++) begin
                // NOTE: non-blocking writes so every register in this block
                // samples pre-edge values, matching real flip-flop behaviour.
                if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        // A write and a read to the same word on one edge return the old
        // word; the LSU never issues both together.
        pipe[0] <= mem[addr];
        for (int s = 1; s < RD_LAT; s++) begin
            pipe[s] <= pipe[s-1];
        end
    end

    assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage load/store unit. It accepts one request when idle. Stores and
// non-memory ops complete in one cycle. Loads stall the stage for RD_LAT
// cycles while the RAM read pipeline fills, then return the extracted and
// extended lane. Misaligned or illegal sizes return o_misalign with zero data
// and do not touch the RAM.
//   i_clk, i_rst         clock / async active-high reset
//   i_valid              request present
//   i_alu                ALU result / byte address
//   i_data               store data
//   i_memRead/Write      load / store (both set = store)
//   i_memToReg           select load result (1) or ALU result (0)
//   i_size, i_unsigned   access size, zero-extend loads
//   o_stall              stage busy with a load
//   o_valid/o_data       one-cycle result strobe and held result
//   o_misalign           access was misaligned (qualified by o_valid)
// ---------------------------------------------------------------------------
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_memRead,
    input  logic              i_memWrite,
    input  logic              i_memToReg,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_misalign
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    state_e            state;
    logic [1:0]        cnt;
    logic [OFF_W-1:0]  cap_off;
    size_e             cap_size;
    logic              cap_unsigned;
    logic              cap_mem_to_reg;
    logic [DATA_W-1:0] cap_alu;

    size_e             size;
    logic [OFF_W-1:0]  off;
    logic [2:0]        off3;
    logic [ADDR_W-1:0] word_addr;
    logic              is_mem;
    logic              is_load;
    logic              misalign;
    logic              we;
    logic [7:0]        be8;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ld_value;

    assign size      = size_e'(i_size);
    assign off       = i_alu[OFF_W-1:0];
    assign off3      = 3'(off);
    assign word_addr = i_alu[OFF_W+ADDR_W-1:OFF_W];
    assign is_mem    = i_memRead | i_memWrite;
    assign is_load   = i_memRead & ~i_memWrite;
    assign o_stall   = (state == WAIT);

    // Alignment is only meaningful for memory ops; pass-through ops never flag.
    always_comb begin
        // NOTE: default first so every path assigns misalign and no latch forms.
        misalign = 1'b0;
        case (size)
            SZ_BYTE:  misalign = 1'b0;
            SZ_HALF:  misalign = off3[0];
            SZ_WORD:  misalign = (off3[1:0] != 2'b00);
            default:  misalign = (DATA_W == 32) || (off3 != 3'b000);
        endcase
        misalign = misalign & is_mem;
    end

    // Replicate store data across all lanes so byte enables alone pick the target.
    always_comb begin
        case (size)
            SZ_BYTE: wdata = {LANES{i_data[7:0]}};
            SZ_HALF: wdata = {(DATA_W/16){i_data[15:0]}};
            SZ_WORD: wdata = {(DATA_W/32){i_data[31:0]}};
            default: wdata = i_data;
        endcase
    end

    assign be8 = lane_be(size, off3);
    assign we  = (state == IDLE) & i_valid & i_memWrite & ~misalign;

    lsu_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (i_clk),
        .addr    (word_addr),
        .wdata   (wdata),
        .byte_en (be8[LANES-1:0]),
        .we      (we),
        .rdata   (rdata)
    );

    // Lane extraction: shift the selected lane to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {cap_off, 3'b000};
        case (cap_size)
            SZ_BYTE: ld_value = cap_unsigned ? DATA_W'(shifted[7:0])
                                             : DATA_W'($signed(shifted[7:0]));
            SZ_HALF: ld_value = cap_unsigned ? DATA_W'(shifted[15:0])
                                             : DATA_W'($signed(shifted[15:0]));
            SZ_WORD: ld_value = cap_unsigned ? DATA_W'(shifted[31:0])
                                             : DATA_W'($signed(shifted[31:0]));
            default: ld_value = shifted;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            o_valid        <= 1'b0;
            o_data         <= '0;
            o_misalign     <= 1'b0;
            cap_off        <= '0;
            cap_size       <= SZ_BYTE;
            cap_unsigned   <= 1'b0;
            cap_mem_to_reg <= 1'b0;
            cap_alu        <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (misalign) begin
                            o_valid    <= 1'b1;
                            o_misalign <= 1'b1;
                            o_data     <= '0;
                        end else if (is_load) begin
                            // The RAM latches word_addr on this same edge.
                            state          <= WAIT;
                            cnt            <= 2'(RD_LAT - 1);
                            cap_off        <= off;
                            cap_size       <= size;
                            cap_unsigned   <= i_unsigned;
                            cap_mem_to_reg <= i_memToReg;
                            cap_alu        <= i_alu;
                        end else begin
                            o_valid <= 1'b1;
                            o_data  <= i_alu;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state   <= IDLE;
                        o_valid <= 1'b1;
                        o_data  <= cap_mem_to_reg ? ld_value : cap_alu;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address bits above the RAM depth wrap by design; lane-mask bits beyond
    // the datapath width exist only for 64-bit builds.
    logic unused_bits;
    assign unused_bits = ^{i_alu[DATA_W-1:OFF_W+ADDR_W], be8};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
// Three LSU instances (RD_LAT = 1, 3, 4) with independent stimulus. Expected
// results come from a byte-addressed little-endian memory model per instance.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

    localparam int NU = 3;
    localparam int LATS [NU] = '{1, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [NU];
    logic        valid_i [NU];
    logic        rd_i    [NU];
    logic        wr_i    [NU];
    logic        m2r_i   [NU];
    logic        uns_i   [NU];
    logic [1:0]  size_i  [NU];
    logic [31:0] alu_i   [NU];
    logic [31:0] data_i  [NU];
    logic        stall_o [NU];
    logic        valid_o [NU];
    logic        mis_o   [NU];
    logic [31:0] data_o  [NU];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        mem_stage_lsu #(
            .DATA_W (32),
            .ADDR_W (10),
            .RD_LAT (LATS[g])
        ) dut (
            .i_clk      (clk),
            .i_rst      (rst[g]),
            .i_valid    (valid_i[g]),
            .i_alu      (alu_i[g]),
            .i_data     (data_i[g]),
            .i_memRead  (rd_i[g]),
            .i_memWrite (wr_i[g]),
            .i_memToReg (m2r_i[g]),
            .i_size     (size_i[g]),
            .i_unsigned (uns_i[g]),
            .o_stall    (stall_o[g]),
            .o_valid    (valid_o[g]),
            .o_data     (data_o[g]),
            .o_misalign (mis_o[g])
        );
    end

    int errors = 0;
    int checks = 0;

    // 1024 words x 4 bytes of byte-addressed reference memory per instance.
    logic [7:0] mb [NU][4096];

    function automatic bit model_mis(input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (sz == 2'd3) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    task automatic model_store(input int u, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) mb[u][(a & 4095) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input int u, input logic [1:0] sz,
                                               input logic uns, input logic [31:0] a);
        int nb = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[u][(a & 4095) + i];
        if (!uns && nb < 4 && v[8*nb-1]) begin
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic drive(input int u, input logic rd, input logic wr, input logic m2r,
                         input logic uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        rd_i[u] = rd; wr_i[u] = wr; m2r_i[u] = m2r; uns_i[u] = uns;
        size_i[u] = sz; alu_i[u] = a; data_i[u] = d;
    endtask

    task automatic wait_accept(input int u, input string name);
        int n = 0;
        while (stall_o[u] === 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 16) begin
            errors++;
            $display("FAIL %s u%0d: stall stuck high, want acceptance within 16 cycles", name, u);
        end
    endtask

    // One request; checks the stall window and the result against the model.
    task automatic run_op(input int u, input string name, input logic rd, input logic wr,
                          input logic m2r, input logic uns, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        bit          mis = model_mis(rd, wr, sz, a);
        bit          ld  = rd && !wr && !mis;
        logic [31:0] exp;
        int          lat;
        if (mis)            exp = '0;
        else if (ld && m2r) exp = model_load(u, sz, uns, a);
        else                exp = a;
        if (wr && !mis) model_store(u, sz, a, d);
        @(negedge clk);
        drive(u, rd, wr, m2r, uns, sz, a, d);
        valid_i[u] = 1'b1;
        wait_accept(u, name);
        @(negedge clk);
        valid_i[u] = 1'b0;
        lat = ld ? LATS[u] : 0;
        for (int k = 0; k < lat; k++) begin
            checks++;
            if (stall_o[u] !== 1'b1 || valid_o[u] !== 1'b0) begin
                errors++;
                $display("FAIL %s u%0d stall cycle %0d: stall=%b valid=%b, want stall=1 valid=0",
                         name, u, k + 1, stall_o[u], valid_o[u]);
            end
            @(negedge clk);
        end
        checks++;
        if (valid_o[u] !== 1'b1 || stall_o[u] !== 1'b0 || data_o[u] !== exp || mis_o[u] !== mis) begin
            errors++;
            $display("FAIL %s u%0d: valid=%b stall=%b data=%h mis=%b, want valid=1 stall=0 data=%h mis=%b",
                     name, u, valid_o[u], stall_o[u], data_o[u], mis_o[u], exp, mis);
        end
    endtask

    task automatic test_reset(input int u);
        rst[u] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o[u] !== 1'b0 || data_o[u] !== 32'h0 || mis_o[u] !== 1'b0 || stall_o[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset u%0d: valid=%b data=%h mis=%b stall=%b, want all 0",
                     u, valid_o[u], data_o[u], mis_o[u], stall_o[u]);
        end
        rst[u] = 1'b0;
        run_op(u, "passthrough", 0, 0, 0, 0, 2'd2, 32'h1234, 32'h0);
    endtask

    task automatic test_init_mem(input int u);
        for (int w = 0; w < 64; w++) run_op(u, "init_sw", 0, 1, 0, 0, 2'd2, w * 4, $urandom);
    endtask

    task automatic test_word(input int u);
        run_op(u, "sw", 0, 1, 0, 0, 2'd2, 32'h40, 32'hDEADBEEF);
        run_op(u, "lw", 1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
    endtask

    task automatic test_subword_load(input int u);
        run_op(u, "lb",  1, 0, 1, 0, 2'd0, 32'h43, 32'h0);
        run_op(u, "lbu", 1, 0, 1, 1, 2'd0, 32'h43, 32'h0);
        run_op(u, "lh",  1, 0, 1, 0, 2'd1, 32'h40, 32'h0);
        run_op(u, "lhu", 1, 0, 1, 1, 2'd1, 32'h42, 32'h0);
        run_op(u, "lw_m2r0", 1, 0, 0, 0, 2'd2, 32'h40, 32'h0);
    endtask

    task automatic test_subword_store(input int u);
        run_op(u, "sb",      0, 1, 0, 0, 2'd0, 32'h41, 32'h55);
        run_op(u, "lw_sb",   1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
        run_op(u, "sh",      0, 1, 0, 0, 2'd1, 32'h42, 32'h1122);
        run_op(u, "lw_sh",   1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
        run_op(u, "rd_wr",   1, 1, 1, 0, 2'd0, 32'h48, 32'hA7);
        run_op(u, "lw_rdwr", 1, 0, 1, 0, 2'd2, 32'h48, 32'h0);
    endtask

    task automatic test_misalign(input int u);
        run_op(u, "lw_mis",   1, 0, 1, 0, 2'd2, 32'h41, 32'h0);
        run_op(u, "sh_mis",   0, 1, 0, 0, 2'd1, 32'h43, 32'hAAAA);
        run_op(u, "sw_mis",   0, 1, 0, 0, 2'd2, 32'h42, 32'h12345678);
        run_op(u, "ld_sz11",  1, 0, 1, 0, 2'd3, 32'h40, 32'h0);
        run_op(u, "st_sz11",  0, 1, 0, 0, 2'd3, 32'h40, 32'h99999999);
        run_op(u, "lw_after", 1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
    endtask

    task automatic test_back_to_back(input int u);
        logic [31:0] exp1 = model_load(u, 2'd2, 1'b0, 32'h40);
        int          lat  = LATS[u];
        @(negedge clk);
        drive(u, 1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
        valid_i[u] = 1'b1;
        wait_accept(u, "b2b");
        @(negedge clk);
        // Second request held from T+1; must be ignored until the stall drops.
        drive(u, 0, 0, 0, 0, 2'd2, 32'hCAFE0, 32'h0);
        for (int k = 1; k <= lat; k++) begin
            checks++;
            if (stall_o[u] !== 1'b1 || valid_o[u] !== 1'b0) begin
                errors++;
                $display("FAIL b2b u%0d stall T+%0d: stall=%b valid=%b, want stall=1 valid=0",
                         u, k, stall_o[u], valid_o[u]);
            end
            @(negedge clk);
        end
        checks++;
        if (valid_o[u] !== 1'b1 || stall_o[u] !== 1'b0 || data_o[u] !== exp1) begin
            errors++;
            $display("FAIL b2b_load u%0d: valid=%b stall=%b data=%h, want valid=1 stall=0 data=%h",
                     u, valid_o[u], stall_o[u], data_o[u], exp1);
        end
        @(negedge clk);
        valid_i[u] = 1'b0;
        checks++;
        if (valid_o[u] !== 1'b1 || data_o[u] !== 32'hCAFE0 || mis_o[u] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second u%0d: valid=%b data=%h mis=%b, want valid=1 data=000cafe0 mis=0",
                     u, valid_o[u], data_o[u], mis_o[u]);
        end
        @(negedge clk);
        checks++;
        if (valid_o[u] !== 1'b0 || data_o[u] !== 32'hCAFE0) begin
            errors++;
            $display("FAIL b2b_pulse u%0d: valid=%b data=%h, want valid=0 data=000cafe0",
                     u, valid_o[u], data_o[u]);
        end
    endtask

    task automatic test_reset_mid_load(input int u);
        int lat = LATS[u];
        @(negedge clk);
        drive(u, 1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
        valid_i[u] = 1'b1;
        wait_accept(u, "rst_load");
        @(negedge clk);
        valid_i[u] = 1'b0;
        @(negedge clk);
        rst[u] = 1'b1;
        #1;
        checks++;
        if (stall_o[u] !== 1'b0 || valid_o[u] !== 1'b0 || data_o[u] !== 32'h0) begin
            errors++;
            $display("FAIL rst_async u%0d: stall=%b valid=%b data=%h, want 0 0 0",
                     u, stall_o[u], valid_o[u], data_o[u]);
        end
        @(negedge clk);
        rst[u] = 1'b0;
        for (int k = 0; k < lat + 2; k++) begin
            @(negedge clk);
            checks++;
            if (valid_o[u] !== 1'b0 || stall_o[u] !== 1'b0) begin
                errors++;
                $display("FAIL rst_abort u%0d cycle %0d: valid=%b stall=%b, want 0 0",
                         u, k, valid_o[u], stall_o[u]);
            end
        end
        run_op(u, "post_rst_lw", 1, 0, 1, 0, 2'd2, 32'h40, 32'h0);
    endtask

    task automatic test_random(input int u);
        for (int i = 0; i < 80; i++) begin
            int          kind = $urandom_range(0, 3);
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic [31:0] a    = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 1) != 0) a = a | 32'h0001_0000;
            run_op(u, "random", kind >= 2, kind == 1 || kind == 3,
                   1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                   sz, a, $urandom);
        end
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1;
            valid_i[u] = 1'b0;
            drive(u, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        end
        for (int u = 0; u < NU; u++) begin
            test_reset(u);
            test_init_mem(u);
            test_word(u);
            test_subword_load(u);
            test_subword_store(u);
            test_misalign(u);
            test_back_to_back(u);
            test_reset_mid_load(u);
            test_random(u);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
